mult_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one sequential shift-add multiplier between NREQ requesters.
- Arbitrates pending requests, latches the winner's operands and pulses start to the multiplier.
- Waits for the multiplier's done, then returns the product, or a timeout error, to the granted requester.
- Sits between client blocks and the multiplier datapath/controller pair.

---
 rtl/mult_share_arb.sv | 161 ++++++++++++++++
 tb/tb_mult_share_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arb.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among NREQ clients.
// Latches the winner's operands, pulses start, waits for done or a watchdog timeout, then responds.
module mult_share_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    mult_start,
    output logic [WIDTH-1:0]        mult_a,
    output logic [WIDTH-1:0]        mult_b,
    input  logic                    mult_done,
    input  logic [2*WIDTH-1:0]      mult_product,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    rsp_err
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned DW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    owner, owner_n;
    logic [CW-1:0]    wdog, wdog_n;
    logic [NREQ-1:0]  grant_n;
    logic             busy_n;
    logic             mult_start_n;
    logic [WIDTH-1:0] mult_a_n, mult_b_n;
    logic [NREQ-1:0]  rsp_valid_n;
    logic [DW-1:0]    rsp_data_n;
    logic             rsp_err_n;

    logic             found_c;
    logic [PW-1:0]    pick_c;
    int unsigned      idx_c;
    logic [PW-1:0]    idx_p_c;

    // Round-robin search: first pending request at or after ptr, wrapping.
    always_comb begin
        found_c = 1'b0;
        pick_c  = '0;
        idx_c   = 0;
        idx_p_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_c = 32'(ptr) + k;
            if (idx_c >= NREQ) begin
                idx_c = idx_c - NREQ;
            end
            idx_p_c = PW'(idx_c);
            if (!found_c && req[idx_p_c]) begin
                found_c = 1'b1;
                pick_c  = idx_p_c;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        owner_n      = owner;
        wdog_n       = wdog;
        grant_n      = grant;
        mult_start_n = 1'b0;
        mult_a_n     = mult_a;
        mult_b_n     = mult_b;
        rsp_valid_n  = '0;
        rsp_data_n   = rsp_data;
        rsp_err_n    = rsp_err;

        case (state)
            S_IDLE: begin
                if (found_c) begin
                    owner_n      = pick_c;
                    grant_n      = NREQ'(1) << pick_c;
                    mult_a_n     = op_a[32'(pick_c)*WIDTH +: WIDTH];
                    mult_b_n     = op_b[32'(pick_c)*WIDTH +: WIDTH];
                    mult_start_n = 1'b1;
                    state_n      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_n  = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                // done wins over a coincident timeout
                if (mult_done) begin
                    rsp_data_n  = mult_product;
                    rsp_err_n   = 1'b0;
                    rsp_valid_n = grant;
                    state_n     = S_RESP;
                end else if (wdog == CW'(TIMEOUT - 1)) begin
                    rsp_data_n  = '0;
                    rsp_err_n   = 1'b1;
                    rsp_valid_n = grant;
                    state_n     = S_RESP;
                end else begin
                    wdog_n = wdog + CW'(1);
                end
            end
            S_RESP: begin
                ptr_n   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                grant_n = '0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            wdog       <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            owner      <= owner_n;
            wdog       <= wdog_n;
            grant      <= grant_n;
            busy       <= busy_n;
            mult_start <= mult_start_n;
            mult_a     <= mult_a_n;
            mult_b     <= mult_b_n;
            rsp_valid  <= rsp_valid_n;
            rsp_data   <= rsp_data_n;
            rsp_err    <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: transaction-level round-robin model plus a latency-programmable multiplier model.
module tb_mult_share_arb;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TIMEOUT = 64;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a, op_b;
    logic [NREQ-1:0]       grant;
    logic                  busy, mult_start;
    logic [WIDTH-1:0]      mult_a, mult_b;
    logic                  mult_done;
    logic [2*WIDTH-1:0]    mult_product;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  rsp_err;

    always #5 clk = ~clk;

    mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
        .grant(grant), .busy(busy), .mult_start(mult_start),
        .mult_a(mult_a), .mult_b(mult_b), .mult_done(mult_done),
        .mult_product(mult_product), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    int total = 0;
    int bad   = 0;

    // reference state
    int               ptr_m;
    logic [WIDTH-1:0] a_m [NREQ];
    logic [WIDTH-1:0] b_m [NREQ];

    // multiplier model state
    int               lat_cfg;
    int               rem;
    logic [WIDTH-1:0] pa, pb;
    bit               spur;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i*WIDTH +: WIDTH] = a_m[i];
            op_b[i*WIDTH +: WIDTH] = b_m[i];
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd_op();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '1;
        if (r == 1) return '0;
        return WIDTH'($urandom);
    endfunction

    task automatic raise(input int i);
        if (!req[i]) begin
            a_m[i] = rnd_op();
            b_m[i] = rnd_op();
            req[i] = 1'b1;
            drive_ops();
        end
    endtask

    // One clock: move to the next falling edge and run the multiplier model.
    task automatic tick();
        @(negedge clk);
        mult_done    = 1'b0;
        mult_product = {$urandom, $urandom};
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                mult_done    = 1'b1;
                mult_product = 64'(pa) * 64'(pb);
            end
        end
        if (mult_start) begin
            rem = lat_cfg;
            pa  = mult_a;
            pb  = mult_b;
        end
        if (spur) begin
            mult_done = 1'b1;
            spur      = 1'b0;
        end
    endtask

    function automatic int pick();
        int idx;
        for (int k = 0; k < NREQ; k++) begin
            idx = (ptr_m + k) % NREQ;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        rem   = 0;
        tick();
        tick();
        reset = 1'b1;
        ptr_m = 0;
        tick();
    endtask

    // One full transaction, called at a falling edge with the DUT idle and req set.
    task automatic txn(input int lat, input bit keep);
        int              w, d, n;
        logic [NREQ-1:0] oh;
        bit              err;
        logic [63:0]     prod;
        w       = pick();
        oh      = NREQ'(1) << w;
        err     = !(lat >= 1 && lat <= int'(TIMEOUT));
        d       = err ? int'(TIMEOUT) + 1 : lat + 1;
        prod    = err ? 64'(0) : 64'(a_m[w]) * 64'(b_m[w]);
        lat_cfg = lat;
        tick();
        check("start", 64'(mult_start), 64'(1));
        check("grant", 64'(grant), 64'(oh));
        check("mult_a", 64'(mult_a), 64'(a_m[w]));
        check("mult_b", 64'(mult_b), 64'(b_m[w]));
        check("busy", 64'(busy), 64'(1));
        n = 0;
        do begin
            tick();
            n++;
        end while (rsp_valid == '0 && n < int'(TIMEOUT) + 10);
        check("rsp_lat", 64'(n), 64'(d));
        check("rsp_valid", 64'(rsp_valid), 64'(oh));
        check("rsp_err", 64'(rsp_err), 64'(err));
        check("rsp_data", rsp_data, prod);
        check("grant_hold", 64'(grant), 64'(oh));
        check("a_hold", 64'(mult_a), 64'(a_m[w]));
        ptr_m = (w + 1) % NREQ;
        if (!keep) req[w] = 1'b0;
        tick();
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_grant", 64'(grant), 64'(0));
        check("rsp_pulse", 64'(rsp_valid), 64'(0));
        check("data_held", rsp_data, prod);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int quiet;
        int lat, r;
        reset = 1'b0; req = '0; op_a = '0; op_b = '0;
        mult_done = 1'b0; mult_product = '0;
        lat_cfg = 0; rem = 0; spur = 1'b0; ptr_m = 0; pa = '0; pb = '0;
        for (int i = 0; i < NREQ; i++) begin a_m[i] = '0; b_m[i] = '0; end
        tick(); tick(); tick();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_start", 64'(mult_start), 64'(0));
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_err", 64'(rsp_err), 64'(0));
        check("rst_a", 64'(mult_a), 64'(0));
        check("rst_data", rsp_data, 64'(0));
        reset = 1'b1;
        tick();

        // single request, L=33
        a_m[1] = 7; b_m[1] = 9; req = 4'b0010; drive_ops();
        txn(33, 1'b0);

        // all four requesting continuously from reset
        req = '0;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin a_m[i] = rnd_op(); b_m[i] = rnd_op(); end
        drive_ops();
        req = '1;
        for (int t = 0; t < 5; t++) txn(int'($urandom_range(1, 8)), 1'b1);
        req = '0;
        tick();

        // timeout, then a normal transaction
        raise(0); txn(0, 1'b0);
        raise(0); txn(5, 1'b0);
        // done coincides with the final watchdog cycle
        raise(2); txn(int'(TIMEOUT), 1'b0);
        // done arrives after the timeout response
        raise(1); txn(int'(TIMEOUT) + 2, 1'b0);
        tick();
        check("late_busy", 64'(busy), 64'(0));
        check("late_valid", 64'(rsp_valid), 64'(0));

        // spurious done in IDLE
        spur = 1'b1;
        tick();
        tick();
        check("spur_busy", 64'(busy), 64'(0));
        check("spur_valid", 64'(rsp_valid), 64'(0));
        check("spur_grant", 64'(grant), 64'(0));

        // boundary operands through requester 3, then ptr wrap
        a_m[3] = '1; b_m[3] = '1; req = 4'b1000; drive_ops();
        txn(20, 1'b0);
        check("max_prod", rsp_data, 64'hFFFFFFFE00000001);
        raise(3); raise(0);
        txn(10, 1'b0);
        txn(3, 1'b0);

        // reset during WAIT
        raise(2); txn(4, 1'b0);
        raise(2);
        lat_cfg = 30;
        tick();
        check("rw_start", 64'(mult_start), 64'(1));
        check("rw_grant", 64'(grant), 64'(4'b0100));
        repeat (5) tick();
        reset = 1'b0;
        tick();
        check("rw_grant0", 64'(grant), 64'(0));
        check("rw_busy0", 64'(busy), 64'(0));
        check("rw_start0", 64'(mult_start), 64'(0));
        check("rw_valid0", 64'(rsp_valid), 64'(0));
        check("rw_a0", 64'(mult_a), 64'(0));
        check("rw_data0", rsp_data, 64'(0));
        tick();
        reset = 1'b1;
        req   = '0;
        ptr_m = 0;
        quiet = 0;
        repeat (30) begin
            tick();
            if (rsp_valid != '0 || busy) quiet++;
        end
        check("rw_quiet", 64'(quiet), 64'(0));
        raise(2); raise(3);
        txn(7, 1'b0);
        txn(7, 1'b0);

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 1) == 1) raise(i);
            end
            if (req == '0) raise(int'($urandom_range(0, NREQ - 1)));
            r = int'($urandom_range(0, 9));
            if (r == 0)      lat = 0;
            else if (r == 1) lat = int'(TIMEOUT);
            else             lat = int'($urandom_range(1, 40));
            txn(lat, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
